// File: rtl/design_2.sv
// Single-clock FIFO of 2**addr_width words with registered read data and registered FULL/EMPTY flags.
// Pointers carry one extra wrap bit, so full and empty are told apart without an occupancy counter.
module design_2 #(
    parameter int addr_width = 10,
    parameter int data_width = 9
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [data_width-1:0] I_DATA,
    input  logic                  W_EN,
    input  logic                  R_EN,
    output logic [data_width-1:0] O_DATA,
    output logic                  FULL,
    output logic                  EMPTY
);

    localparam int DEPTH = 1 << addr_width;
    localparam logic [addr_width:0] PTR_ONE = {{addr_width{1'b0}}, 1'b1};

    logic [data_width-1:0] mem [DEPTH];

    logic [addr_width:0]   wptr_q, wptr_d;
    logic [addr_width:0]   rptr_q, rptr_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [data_width-1:0] rdata_q;
    logic                  wr_ok, rd_ok;

    always_comb begin
        wr_ok  = W_EN & ~full_q;
        rd_ok  = R_EN & ~empty_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_ok) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_ok) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        // Flags come from the next-state pointers so they are exact right after every edge.
        empty_d = (wptr_d == rptr_d);
        full_d  = (wptr_d[addr_width] != rptr_d[addr_width]) &&
                  (wptr_d[addr_width-1:0] == rptr_d[addr_width-1:0]);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage is never reset; reset only has to block writes issued in the same cycle.
    always_ff @(posedge CLK) begin
        if (!RST && wr_ok) begin
            mem[wptr_q[addr_width-1:0]] <= I_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata_q <= '0;
        end else if (rd_ok) begin
            rdata_q <= mem[rptr_q[addr_width-1:0]];
        end
    end

    assign O_DATA = rdata_q;
    assign FULL   = full_q;
    assign EMPTY  = empty_q;

endmodule

// File: tb/tb_design_2.sv
// Directed bench for design_2: stimulus pushes expected read words into a scoreboard queue,
// and a monitor pops and compares O_DATA after every edge.
module tb_design_2;

    localparam int AW    = 10;
    localparam int DW    = 9;
    localparam int DEPTH = 1 << AW;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          w_en   = 1'b1;
    logic          r_en   = 1'b1;
    logic [DW-1:0] i_data = 9'h055;
    logic [DW-1:0] o_data;
    logic          full;
    logic          empty;

    always #5 clk = ~clk;

    design_2 #(.addr_width(AW), .data_width(DW)) dut (
        .CLK    (clk),
        .RST    (rst),
        .I_DATA (i_data),
        .W_EN   (w_en),
        .R_EN   (r_en),
        .O_DATA (o_data),
        .FULL   (full),
        .EMPTY  (empty)
    );

    int            errors  = 0;
    int            checks  = 0;
    bit            verbose = 1'b1;
    logic [DW-1:0] model[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_o  = '0;
    bit            rd_exp  = 1'b0;
    bit            rst_exp = 1'b1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of traffic; the reference queue decides acceptance from bench state only.
    task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d);
        bit wr_ok, rd_ok;
        wr_ok   = w && (model.size() < DEPTH);
        rd_ok   = r && (model.size() > 0);
        rst     = 1'b0;
        w_en    = w;
        r_en    = r;
        i_data  = d;
        rst_exp = 1'b0;
        rd_exp  = rd_ok;
        if (rd_ok) exp_q.push_back(model.pop_front());
        if (wr_ok) model.push_back(d);
        @(posedge clk);
        #1;
        check("EMPTY", {{(DW-1){1'b0}}, empty}, {{(DW-1){1'b0}}, model.size() == 0});
        check("FULL",  {{(DW-1){1'b0}}, full},  {{(DW-1){1'b0}}, model.size() == DEPTH});
        if (verbose)
            $display("txn w=%0d r=%0d d=%h -> o=%h empty=%0d full=%0d occ=%0d",
                     w, r, d, o_data, empty, full, model.size());
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            rst     = 1'b1;
            w_en    = 1'b1;
            r_en    = 1'b1;
            i_data  = 9'h0AA;
            rst_exp = 1'b1;
            rd_exp  = 1'b0;
            model.delete();
            @(posedge clk);
            #1;
            check("EMPTY after reset", {{(DW-1){1'b0}}, empty}, 9'h001);
            check("FULL after reset",  {{(DW-1){1'b0}}, full},  9'h000);
            if (verbose) $display("txn reset -> o=%h empty=%0d full=%0d", o_data, empty, full);
        end
        rst = 1'b0;
    endtask

    // Monitor: compares O_DATA after every edge against reset value, popped word or held value.
    initial begin
        bit cap_rd, cap_rst;
        logic [DW-1:0] e;
        forever begin
            @(posedge clk);
            cap_rd  = rd_exp;
            cap_rst = rst_exp;
            #1;
            if (cap_rst) begin
                last_o = '0;
                check("O_DATA reset", o_data, '0);
            end else if (cap_rd) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL O_DATA read: got %h expected none queued", o_data);
                end else begin
                    e = exp_q.pop_front();
                    check("O_DATA read", o_data, e);
                    last_o = e;
                end
            end else begin
                check("O_DATA hold", o_data, last_o);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with both enables high; nothing may be written.
        do_reset(2);
        cycle(1'b0, 1'b1, 9'h000);

        // Single word.
        cycle(1'b1, 1'b0, 9'h1B3);
        cycle(1'b0, 1'b1, 9'h000);

        // Fill, overflow attempt, drain.
        verbose = 1'b0;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(i % 512));
        verbose = 1'b1;
        cycle(1'b1, 1'b0, 9'h0AA);
        cycle(1'b1, 1'b1, 9'h0AB);
        verbose = 1'b0;
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 9'h000);
        verbose = 1'b1;

        // Underflow, then a round trip.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 9'h000);
        cycle(1'b1, 1'b0, 9'h123);
        cycle(1'b0, 1'b1, 9'h000);

        // Sustained simultaneous traffic at occupancy 3.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, DW'(9'h100 + i));
        verbose = 1'b0;
        for (int i = 0; i < 2000; i++) cycle(1'b1, 1'b1, DW'(i + 3));
        verbose = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 9'h000);

        // Mid-operation reset discards stored words.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, DW'(9'h040 + i));
        do_reset(1);
        cycle(1'b1, 1'b0, 9'h1C7);
        cycle(1'b0, 1'b1, 9'h000);
        cycle(1'b0, 1'b1, 9'h000);
        cycle(1'b0, 1'b0, 9'h000);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
